split: RTL and testbench

Controlled split: one token consumed from data input L and one from control input C are routed to output A (C_data = 0) or output B (C_data = 1) through a registered one-entry stage per output. It is the demultiplexing counterpart of the controlled merge and pairs with it to build conditional dataflow (branch, then rejoin). It sits between valid/ready channels anywhere in the dataflow fabric.

---
 rtl/split.sv | 107 ++++++++++
 tb/tb_split.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/split.sv
// Controlled split: one L token plus one C token is routed to output A (C_data = 0)
// or output B (C_data = 1), each output buffered by an independent one-entry slot.

// One-entry output slot with registered data/valid and same-cycle drain+reload.
//   state      | meaning
//   SLOT_EMPTY | no token held, valid low
//   SLOT_FULL  | token held; data/valid frozen until downstream ready
module split_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] slot_data,
    output logic             slot_valid,
    output logic             slot_free
);

    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

    logic [0:0]       slot_state;
    logic [WIDTH-1:0] data_reg;

    assign slot_valid = (slot_state == SLOT_FULL);
    assign slot_data  = data_reg;
    assign slot_free  = (slot_state == SLOT_EMPTY) || ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_state <= SLOT_EMPTY;
            data_reg   <= '0;
        end else if (load) begin
            slot_state <= SLOT_FULL;
            data_reg   <= load_data;
        end else if (ready) begin
            // data is kept so the bus does not toggle when nothing is offered
            slot_state <= SLOT_EMPTY;
        end
    end

endmodule

module split #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] L_data,
    input  logic             L_valid,
    output logic             L_ready,
    input  logic             C_data,
    input  logic             C_valid,
    output logic             C_ready,
    output logic [WIDTH-1:0] A_data,
    output logic             A_valid,
    input  logic             A_ready,
    output logic [WIDTH-1:0] B_data,
    output logic             B_valid,
    input  logic             B_ready
);

    logic pair_valid;
    logic sel_a;
    logic sel_b;
    logic a_free;
    logic b_free;
    logic fire_a;
    logic fire_b;
    logic fire;

    assign pair_valid = L_valid && C_valid;
    assign sel_a      = pair_valid && (C_data == 1'b0);
    assign sel_b      = pair_valid && (C_data == 1'b1);
    assign fire_a     = sel_a && a_free;
    assign fire_b     = sel_b && b_free;

    // reset gates the handshake so no token is consumed while state is being cleared
    assign fire    = reset && (fire_a || fire_b);
    assign L_ready = fire;
    assign C_ready = fire;

    split_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk        (clk),
        .reset      (reset),
        .load       (fire_a),
        .load_data  (L_data),
        .ready      (A_ready),
        .slot_data  (A_data),
        .slot_valid (A_valid),
        .slot_free  (a_free)
    );

    split_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk        (clk),
        .reset      (reset),
        .load       (fire_b),
        .load_data  (L_data),
        .ready      (B_ready),
        .slot_data  (B_data),
        .slot_valid (B_valid),
        .slot_free  (b_free)
    );

endmodule

// File: tb/tb_split.sv
// Randomized and directed bench for split, checked against a queue-based model
// of the two one-entry output buffers.
module tb_split;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] L_data;
    logic        L_valid;
    logic        L_ready;
    logic        C_data;
    logic        C_valid;
    logic        C_ready;
    logic [63:0] A_data;
    logic        A_valid;
    logic        A_ready;
    logic [63:0] B_data;
    logic        B_valid;
    logic        B_ready;

    int n_checks = 0;
    int n_pass   = 0;

    // model: tokens waiting at each output, plus the last value each output presented
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] last_a;
    logic [63:0] last_b;
    int          sent_a;
    int          got_a;
    int          sent_b;
    int          got_b;

    split #(.WIDTH(64)) dut (
        .clk     (clk),
        .reset   (reset),
        .L_data  (L_data),
        .L_valid (L_valid),
        .L_ready (L_ready),
        .C_data  (C_data),
        .C_valid (C_valid),
        .C_ready (C_ready),
        .A_data  (A_data),
        .A_valid (A_valid),
        .A_ready (A_ready),
        .B_data  (B_data),
        .B_valid (B_valid),
        .B_ready (B_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // One cycle: drive inputs after the falling edge, check outputs, then let the
    // rising edge happen and advance the model with the same inputs.
    task automatic step(input logic rst, input logic lv, input logic cv, input logic cd,
                        input logic ar, input logic br, input logic [63:0] ld);
        logic take;
        @(negedge clk);
        reset   = rst;
        L_valid = lv;
        C_valid = cv;
        C_data  = cd;
        A_ready = ar;
        B_ready = br;
        L_data  = ld;
        #1;
        if (!rst) take = 1'b0;
        else if (!(lv && cv)) take = 1'b0;
        else if (cd) take = (q_b.size() == 0) || br;
        else take = (q_a.size() == 0) || ar;
        chk("L_ready", {63'd0, L_ready}, {63'd0, take});
        chk("C_ready", {63'd0, C_ready}, {63'd0, take});
        chk("A_valid", {63'd0, A_valid}, {63'd0, q_a.size() != 0});
        chk("B_valid", {63'd0, B_valid}, {63'd0, q_b.size() != 0});
        chk("A_data", A_data, last_a);
        chk("B_data", B_data, last_b);
        @(posedge clk);
        if (!rst) begin
            q_a.delete();
            q_b.delete();
            last_a = '0;
            last_b = '0;
        end else begin
            if (ar && q_a.size() != 0) begin void'(q_a.pop_front()); got_a++; end
            if (br && q_b.size() != 0) begin void'(q_b.pop_front()); got_b++; end
            if (take && !cd) begin q_a.push_back(ld); last_a = ld; sent_a++; end
            if (take && cd)  begin q_b.push_back(ld); last_b = ld; sent_b++; end
        end
    endtask

    initial begin
        reset   = 1'b0;
        L_valid = 1'b0;
        C_valid = 1'b0;
        C_data  = 1'b0;
        A_ready = 1'b0;
        B_ready = 1'b0;
        L_data  = '0;
        last_a  = '0;
        last_b  = '0;
        sent_a  = 0;
        got_a   = 0;
        sent_b  = 0;
        got_b   = 0;
        @(posedge clk);

        // reset with tokens offered: nothing consumed
        step(0, 1, 1, 0, 1, 1, 64'h5555);
        step(0, 1, 1, 1, 1, 1, 64'h6666);

        // basic routing, first cycle out of reset accepts
        step(1, 1, 1, 0, 1, 1, 64'h1111);
        step(1, 1, 1, 1, 1, 1, 64'h2222);
        step(1, 0, 0, 0, 1, 1, 64'h0);
        step(1, 0, 0, 0, 1, 1, 64'h0);

        // back-pressure on A, then release
        step(1, 1, 1, 0, 0, 1, 64'hAAAA);
        step(1, 1, 1, 0, 0, 1, 64'hBBBB);
        step(1, 1, 1, 0, 0, 1, 64'hBBBB);
        step(1, 1, 1, 0, 1, 1, 64'hBBBB);
        step(1, 0, 0, 0, 0, 1, 64'h0);

        // A stalled full, 8 tokens stream through B
        for (int i = 0; i < 8; i++) step(1, 1, 1, 1, 0, 1, 64'hB000 + 64'(i));
        step(1, 0, 0, 0, 0, 1, 64'h0);
        chk("A_held", A_data, 64'hBBBB);

        // L waits for C
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0, 1, 64'hC0DE);
        step(1, 1, 1, 1, 0, 1, 64'hC0DE);

        // both full and stalled, one-cycle reset clears them
        step(1, 1, 1, 1, 0, 0, 64'hD00D);
        step(0, 1, 1, 0, 0, 0, 64'hE00E);
        step(1, 1, 1, 0, 1, 1, 64'hF00F);
        step(1, 0, 0, 0, 1, 1, 64'h0);

        // alternating A/B at full rate
        for (int i = 0; i < 10; i++) step(1, 1, 1, i[0], 1, 1, 64'hA100 + 64'(i));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6),
                 {$urandom, $urandom});
        end

        // drain and confirm accounting matches the model
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 1, 64'h0);
        chk("A_drained", 64'(q_a.size()), 64'd0);
        chk("B_drained", 64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
